reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width.
REQ-002 SHALL provide parameter ADDR_W, default 4, register index width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter PC_W, default 16, program-counter width (PC_W <= DATA_W).
REQ-004 SHALL provide parameter PC_IDX, default 15, index aliased to the PC.
REQ-005 SHALL provide parameter RESET_PC, default 0, PC value after reset.
REQ-006 Ports (name  direction  width  meaning):
  CLOCK_50  in  1  sole clock, rising edge.
  RESET  in  1  synchronous, active-high reset.
  ARn, ARs, ARm  in  ADDR_W each  read-port addresses.
  ARd  in  ADDR_W  write address, also the fourth read-port address.
  write_en  in  1  register write strobe.
  write_data  in  DATA_W  write value.
  PC_next  in  PC_W  sequential PC candidate.
  PC_en  in  1  PC advance enable; low = stall.
  sb_set  in  1  mark register sb_addr pending.
  sb_addr  in  ADDR_W  scoreboard target.
  Rn, Rs, Rm, Rd  out  DATA_W each  read data.
  busy_n, busy_s, busy_m  out  1 each  pending flag of ARn/ARs/ARm.
  PC_out  out  PC_W  current PC.

Function
REQ-007 Reads SHALL be combinational from the register array; zero latency.
REQ-008 Reading index PC_IDX SHALL return PC_out zero-extended to DATA_W.
REQ-009 write_en high SHALL update register ARd with write_data on the rising edge; visible on reads the following cycle.
REQ-010 PC SHALL load PC_next on the edge when PC_en=1 and no PC write occurs; hold when PC_en=0.
REQ-011 write_en with ARd=PC_IDX SHALL load write_data[PC_W-1:0] into the PC, overriding PC_next and PC_en (branch).
REQ-012 sb_set SHALL set the busy bit of sb_addr on the edge.
REQ-013 write_en SHALL clear the busy bit of ARd on the edge.
REQ-014 Same-edge sb_set and write_en to the same index SHALL leave the bit set (new issue wins).
REQ-015 busy_n/s/m SHALL be combinational lookups of the busy bits at ARn/ARs/ARm.
REQ-016 The PC_IDX busy bit SHALL always read 0; sb_set to PC_IDX is ignored.
REQ-017 PC arithmetic SHALL wrap modulo 2**PC_W; the block performs no increment itself.

Reset
REQ-018 On an edge with RESET=1: all registers 0, all busy bits 0, PC = RESET_PC; write_en, sb_set and PC_en are ignored on that edge.
REQ-019 Outputs after reset: Rn/Rs/Rm/Rd = 0 (PC_IDX reads RESET_PC), busy_* = 0, PC_out = RESET_PC.
REQ-020 RESET asserted mid-operation SHALL discard pending scoreboard state with no side effect.

Configuration
REQ-021 Macro RF_BYPASS_EN defined: a read whose address equals ARd while write_en=1 SHALL return write_data in the same cycle (PC_IDX included, truncated/zero-extended), and its busy_* output SHALL read 0.
REQ-022 RF_BYPASS_EN undefined: reads SHALL return the stored value; new data appears the next cycle.

Structure
REQ-023 Package rf_pkg SHALL hold default parameter constants (DATA_W, ADDR_W, PC_W, PC_IDX) and a reg-index typedef.
REQ-024 Busy-bit array and its set/clear/priority logic SHALL live in sub-module rf_scoreboard.

Verification
REQ-025 Writes R7=19, R3=21, R4=20, R2=27 on consecutive edges, then ARn=7, ARs=3, ARm=4, ARd=2 -> Rn=19, Rs=21, Rm=20, Rd=27.
REQ-026 PC_en=1, PC_next=5; then write_en, ARd=15, write_data=99 on the same edge -> PC_out=99; read of index 15 -> 99.
REQ-027 sb_set, sb_addr=3; next cycle ARs=3 -> busy_s=1; write R3=8 -> busy_s=0 next cycle; same-edge set+write to R3 -> busy stays 1.
REQ-028 PC_en=0 for 3 cycles with PC_next changing -> PC_out constant.
REQ-029 RESET=1 for one edge after the above -> all reads 0, PC_out=RESET_PC, all busy 0.
REQ-030 With RF_BYPASS_EN: write_en, ARd=ARn=7, write_data=0x55 -> Rn=0x55 same cycle; without the macro, Rn shows the old value until the next edge.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// rf_pkg: default sizing constants and the register-index type shared by
// the register file, its scoreboard and its bus interface.
package rf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int PC_W_DEF   = 16;
    localparam int PC_IDX_DEF = 15;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read/write/scoreboard/PC bus of the register file.
// master = core side driving addresses and strobes, slave = register file.
interface reg_file_mp_if import rf_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PC_W   = PC_W_DEF
);
    logic [ADDR_W-1:0] ARn, ARs, ARm, ARd;
    logic              write_en;
    logic [DATA_W-1:0] write_data;
    logic [PC_W-1:0]   PC_next;
    logic              PC_en;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [DATA_W-1:0] Rn, Rs, Rm, Rd;
    logic              busy_n, busy_s, busy_m;
    logic [PC_W-1:0]   PC_out;

    modport master (
        output ARn, ARs, ARm, ARd, write_en, write_data, PC_next, PC_en, sb_set, sb_addr,
        input  Rn, Rs, Rm, Rd, busy_n, busy_s, busy_m, PC_out
    );
    modport slave (
        input  ARn, ARs, ARm, ARd, write_en, write_data, PC_next, PC_en, sb_set, sb_addr,
        output Rn, Rs, Rm, Rd, busy_n, busy_s, busy_m, PC_out
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// rf_scoreboard: one pending bit per register. A write retires the bit of
// its destination, a same-edge issue to that index wins, and the PC index
// can never become pending.
module rf_scoreboard import rf_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int PORTS  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_en,
    input  logic [ADDR_W-1:0]             set_addr,
    input  logic                          clr_en,
    input  logic [ADDR_W-1:0]             clr_addr,
    input  logic [PORTS-1:0][ADDR_W-1:0]  look_addr,
    output logic [PORTS-1:0]              look_busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DEPTH-1:0] busy, busy_nxt;

    // clear first, then set, so a new issue overrides a retiring write
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (set_en && (set_addr != PC_A))
            busy_nxt[set_addr] = 1'b1;
        busy_nxt[PC_A] = 1'b0;
    end

    // pending-bit state; reset drops every outstanding issue
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // per-port pending lookup
    always_comb begin
        for (int p = 0; p < PORTS; p++)
            look_busy[p] = busy[look_addr[p]];
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 4-read / 1-write register file with the PC aliased at
// index PC_IDX and a per-register pending scoreboard.
// Optional feature macro RF_BYPASS_EN: reads of the address being written
// return write_data in the same cycle and report not-busy.
module reg_file_mp import rf_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int PC_IDX   = PC_IDX_DEF,
    parameter int RESET_PC = 0
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]             regs [DEPTH];
    logic [PC_W-1:0]               pc;
    logic                          branch;
    logic [3:0][ADDR_W-1:0]        rd_addr;
    logic [3:0][DATA_W-1:0]        rd_data;
    logic [2:0]                    byp;
    logic [2:0]                    sb_busy;

    assign branch  = bus.write_en && (bus.ARd == PC_A);
    assign rd_addr = {bus.ARd, bus.ARm, bus.ARs, bus.ARn};

    // general registers; the PC slot in the array is never written
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (bus.write_en && !branch) begin
            regs[bus.ARd] <= bus.write_data;
        end
    end

    // PC: branch write beats sequential advance; PC_en low stalls
    always_ff @(posedge CLOCK_50) begin
        if (RESET)        pc <= PC_W'(RESET_PC);
        else if (branch)  pc <= bus.write_data[PC_W-1:0];
        else if (bus.PC_en) pc <= bus.PC_next;
    end

    // combinational read ports, PC index aliased, optional write bypass
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            rd_data[g] = (rd_addr[g] == PC_A) ? DATA_W'(pc) : regs[rd_addr[g]];
`ifdef RF_BYPASS_EN
            if (bus.write_en && (rd_addr[g] == bus.ARd))
                rd_data[g] = (bus.ARd == PC_A) ? DATA_W'(bus.write_data[PC_W-1:0])
                                               : bus.write_data;
`endif
        end
    end

    // bypassed reads see retired data, so their pending flag is masked
    always_comb begin
        for (int g = 0; g < 3; g++) begin
            byp[g] = 1'b0;
`ifdef RF_BYPASS_EN
            byp[g] = bus.write_en && (rd_addr[g] == bus.ARd);
`endif
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .PC_IDX (PC_IDX),
        .PORTS  (3)
    ) u_sb (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .set_en    (bus.sb_set),
        .set_addr  (bus.sb_addr),
        .clr_en    (bus.write_en),
        .clr_addr  (bus.ARd),
        .look_addr (rd_addr[2:0]),
        .look_busy (sb_busy)
    );

    assign bus.Rn     = rd_data[0];
    assign bus.Rs     = rd_data[1];
    assign bus.Rm     = rd_data[2];
    assign bus.Rd     = rd_data[3];
    assign bus.busy_n = sb_busy[0] & ~byp[0];
    assign bus.busy_s = sb_busy[1] & ~byp[1];
    assign bus.busy_m = sb_busy[2] & ~byp[2];
    assign bus.PC_out = pc;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed stimulus with a behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_reg_file_mp;
    localparam int DW = 32, AW = 4, PW = 16, PCI = 15, RPC = 0;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) bus();

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .PC_IDX(PCI), .RESET_PC(RPC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking_on = 0;

    // behavioural model state
    logic [31:0] mregs [16];
    logic [15:0] mpc;
    bit          mbusy [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
`ifdef RF_BYPASS_EN
        if (bus.write_en && a == bus.ARd)
            return (int'(a) == PCI) ? {16'h0, bus.write_data[15:0]} : bus.write_data;
`endif
        if (int'(a) == PCI) return {16'h0, mpc};
        return mregs[a];
    endfunction

    function automatic logic [31:0] mbsy(input logic [3:0] a);
`ifdef RF_BYPASS_EN
        if (bus.write_en && a == bus.ARd) return 32'd0;
`endif
        return {31'd0, mbusy[a]};
    endfunction

    // model update on the active edge
    always @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin
                mregs[i] = 32'd0;
                mbusy[i] = 1'b0;
            end
            mpc = 16'(RPC);
        end else begin
            if (bus.write_en && int'(bus.ARd) == PCI) mpc = bus.write_data[15:0];
            else if (bus.PC_en)                        mpc = bus.PC_next;
            if (bus.write_en && int'(bus.ARd) != PCI)  mregs[bus.ARd] = bus.write_data;
            if (bus.write_en)                          mbusy[bus.ARd] = 1'b0;
            if (bus.sb_set && int'(bus.sb_addr) != PCI) mbusy[bus.sb_addr] = 1'b1;
        end
    end

    // every-cycle comparison against the model
    always @(negedge CLOCK_50) begin
        if (checking_on) begin
            chk("m_Rn", bus.Rn, mread(bus.ARn));
            chk("m_Rs", bus.Rs, mread(bus.ARs));
            chk("m_Rm", bus.Rm, mread(bus.ARm));
            chk("m_Rd", bus.Rd, mread(bus.ARd));
            chk("m_busy_n", {31'd0, bus.busy_n}, mbsy(bus.ARn));
            chk("m_busy_s", {31'd0, bus.busy_s}, mbsy(bus.ARs));
            chk("m_busy_m", {31'd0, bus.busy_m}, mbsy(bus.ARm));
            chk("m_PC_out", {16'd0, bus.PC_out}, {16'd0, mpc});
        end
    end

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle();
        bus.write_en = 1'b0;
        bus.sb_set   = 1'b0;
        bus.PC_en    = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.write_en   = 1'b1;
        bus.ARd        = a;
        bus.write_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  a7    [4];
        logic [31:0] d7    [4];
        a7 = '{4'd7, 4'd3, 4'd4, 4'd2};
        d7 = '{32'd19, 32'd21, 32'd20, 32'd27};

        bus.ARn = 4'd0; bus.ARs = 4'd0; bus.ARm = 4'd0; bus.ARd = 4'd0;
        bus.write_data = 32'd0; bus.PC_next = 16'd0; bus.sb_addr = 4'd0;
        idle();

        // reset state
        cyc();
        checking_on = 1;
        RESET = 1'b0;
        bus.ARm = 4'd15;
        #1;
        chk("rst_Rn", bus.Rn, 32'd0);
        chk("rst_Rm_pc", bus.Rm, 32'd0);
        chk("rst_PC", {16'd0, bus.PC_out}, 32'd0);
        chk("rst_busy_n", {31'd0, bus.busy_n}, 32'd0);

        // four writes, then four reads
        for (int i = 0; i < 4; i++) begin
            wr(a7[i], d7[i]);
            cyc();
        end
        idle();
        bus.ARn = 4'd7; bus.ARs = 4'd3; bus.ARm = 4'd4; bus.ARd = 4'd2;
        #1;
        chk("rd_Rn", bus.Rn, 32'd19);
        chk("rd_Rs", bus.Rs, 32'd21);
        chk("rd_Rm", bus.Rm, 32'd20);
        chk("rd_Rd", bus.Rd, 32'd27);

        // sequential advance, then branch overriding PC_en
        bus.PC_en = 1'b1; bus.PC_next = 16'd5;
        cyc();
        idle();
        #1;
        chk("pc_adv", {16'd0, bus.PC_out}, 32'd5);
        wr(4'd15, 32'd99);
        bus.PC_en = 1'b1; bus.PC_next = 16'd6;
        cyc();
        idle();
        bus.ARn = 4'd15;
        #1;
        chk("pc_branch", {16'd0, bus.PC_out}, 32'd99);
        chk("pc_read15", bus.Rn, 32'd99);

        // stall with PC_next changing
        for (int i = 0; i < 3; i++) begin
            bus.PC_en = 1'b0; bus.PC_next = 16'(7 + i);
            cyc();
            chk("pc_stall", {16'd0, bus.PC_out}, 32'd99);
        end

        // branch value truncated to PC width, read back zero-extended
        wr(4'd15, 32'h0001_2345);
        cyc();
        idle();
        #1;
        chk("pc_trunc", {16'd0, bus.PC_out}, 32'h2345);
        chk("pc_zext", bus.Rn, 32'h0000_2345);
        bus.PC_en = 1'b1; bus.PC_next = 16'hFFFF;
        cyc();
        idle();
        #1;
        chk("pc_max", {16'd0, bus.PC_out}, 32'hFFFF);

        // scoreboard set / clear / same-edge priority / PC index ignored
        bus.sb_set = 1'b1; bus.sb_addr = 4'd3; bus.ARs = 4'd3;
        cyc();
        idle();
        #1;
        chk("sb_set", {31'd0, bus.busy_s}, 32'd1);
        wr(4'd3, 32'd8);
        cyc();
        idle();
        #1;
        chk("sb_clr", {31'd0, bus.busy_s}, 32'd0);
        chk("sb_clr_data", bus.Rs, 32'd8);
        wr(4'd3, 32'd10);
        bus.sb_set = 1'b1; bus.sb_addr = 4'd3;
        cyc();
        idle();
        #1;
        chk("sb_prio", {31'd0, bus.busy_s}, 32'd1);
        chk("sb_prio_data", bus.Rs, 32'd10);
        bus.sb_set = 1'b1; bus.sb_addr = 4'd15; bus.ARn = 4'd15;
        cyc();
        bus.sb_addr = 4'd5;
        cyc();
        bus.sb_addr = 4'd9;
        cyc();
        idle();
        #1;
        chk("sb_pc_ignored", {31'd0, bus.busy_n}, 32'd0);
        bus.ARn = 4'd5; bus.ARm = 4'd9;
        #1;
        chk("sb_busy_n", {31'd0, bus.busy_n}, 32'd1);
        chk("sb_busy_m", {31'd0, bus.busy_m}, 32'd1);

        // same-cycle read of the register being written
        bus.ARn = 4'd7;
        wr(4'd7, 32'h55);
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_same", bus.Rn, 32'h55);
`else
        chk("byp_same", bus.Rn, 32'd19);
`endif
        cyc();
        idle();
        #1;
        chk("byp_next", bus.Rn, 32'h55);

        // reset mid-operation with every strobe active
        RESET = 1'b1;
        wr(4'd4, 32'd77);
        bus.sb_set = 1'b1; bus.sb_addr = 4'd6;
        bus.PC_en = 1'b1; bus.PC_next = 16'd40;
        cyc();
        RESET = 1'b0;
        idle();
        bus.ARn = 4'd5; bus.ARs = 4'd3; bus.ARm = 4'd9; bus.ARd = 4'd15;
        #1;
        chk("rst2_Rs", bus.Rs, 32'd0);
        chk("rst2_Rd_pc", bus.Rd, 32'd0);
        chk("rst2_PC", {16'd0, bus.PC_out}, 32'd0);
        chk("rst2_busy_n", {31'd0, bus.busy_n}, 32'd0);
        chk("rst2_busy_s", {31'd0, bus.busy_s}, 32'd0);
        chk("rst2_busy_m", {31'd0, bus.busy_m}, 32'd0);
        bus.ARn = 4'd4; bus.ARs = 4'd6; bus.ARm = 4'd7;
        #1;
        chk("rst2_R4", bus.Rn, 32'd0);
        chk("rst2_busy6", {31'd0, bus.busy_s}, 32'd0);
        chk("rst2_R7", bus.Rm, 32'd0);
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
